// File: rtl/product_accum_pkg.sv
// ---------------------------------------------------------------------------
// product_accum_pkg
//   Shared definitions for the product accumulator and its neighbours.
//   - PROD_W      : product width, common with the 2x2-bit multiplier
//   - state_t     : accumulator FSM state encoding
//   - clog2()     : ceiling log2, usable in parameter expressions
// ---------------------------------------------------------------------------
package product_accum_pkg;

  // Product width fixed by the upstream 2-bit x 2-bit multiplier.
  localparam int PROD_W = 4;

  // ACC: collecting products, OUT: block result waiting for downstream.
  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  // Ceiling log2. Returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (remain > 0) begin
        result = result + 1;
        remain = remain >> 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/product_accum.sv
// ---------------------------------------------------------------------------
// product_accum
//   Accumulates 4-bit multiplier products into a running block sum. A block
//   closes after BLOCK_LEN products or earlier on prod_last; the block sum,
//   product count and overflow flag are then offered downstream and the
//   accumulator clears once the result is taken.
//
// Parameters
//   ACC_W      accumulator / sum width (4..16)
//   BLOCK_LEN  maximum products per block (1..255)
//   CNT_W      width of the count field, clog2(BLOCK_LEN+1)
//
// Ports
//   clk         in   clock, rising edge
//   rst_n       in   synchronous active-low reset
//   prod_valid  in   upstream product valid
//   prod_ready  out  block can accept a product
//   prod_data   in   product value
//   prod_last   in   close the block after this product
//   sum_valid   out  block result available
//   sum_ready   in   downstream accepts the result
//   sum_data    out  block sum modulo 2^ACC_W
//   sum_count   out  products in the block, 1..BLOCK_LEN
//   sum_ovf     out  a carry out of ACC_W occurred during the block
// ---------------------------------------------------------------------------
module product_accum
  import product_accum_pkg::*;
#(
  parameter  int ACC_W     = 8,
  parameter  int BLOCK_LEN = 4,
  localparam int CNT_W     = clog2(BLOCK_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod_data,
  input  logic              prod_last,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [ACC_W-1:0]  sum_data,
  output logic [CNT_W-1:0]  sum_count,
  output logic              sum_ovf
);

  state_t state_reg;
  state_t state_next;

  logic [ACC_W-1:0] acc_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             ovf_reg;

  logic [ACC_W-1:0] sum_data_reg;
  logic [CNT_W-1:0] sum_count_reg;
  logic             sum_ovf_reg;

  logic             prod_fire;
  logic             sum_fire;
  logic             is_final;
  logic [ACC_W:0]   acc_plus;
  logic             carry;
  logic [CNT_W-1:0] cnt_inc;

  // Count value held just before the BLOCK_LEN-th product arrives.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);

  // -------------------------------------------------------------------------
  // Datapath arithmetic: one extra bit on the adder captures the carry that
  // feeds the sticky overflow flag.
  // -------------------------------------------------------------------------
  assign acc_plus  = {1'b0, acc_reg} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_data};
  assign carry     = acc_plus[ACC_W];
  assign cnt_inc   = cnt_reg + CNT_W'(1);
  assign is_final  = (cnt_reg == LAST_CNT) | prod_last;

  assign prod_fire = prod_valid & prod_ready;
  assign sum_fire  = sum_valid & sum_ready;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_ACC;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_ACC: begin
        if (prod_fire && is_final) begin
          state_next = ST_OUT;
        end
      end
      ST_OUT: begin
        if (sum_ready) begin
          state_next = ST_ACC;
        end
      end
      default: state_next = ST_ACC;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs. rst_n gates prod_ready so nothing can be accepted while
  // reset is asserted, even though the state register still reads ACC.
  // -------------------------------------------------------------------------
  always_comb begin
    prod_ready = 1'b0;
    sum_valid  = 1'b0;
    case (state_reg)
      ST_ACC:  prod_ready = rst_n;
      ST_OUT:  sum_valid  = 1'b1;
      default: prod_ready = 1'b0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Accumulator, counter and result registers. The result is captured on
  // the edge that accepts the final product, so it is visible one cycle
  // after that handshake and holds until the next final product.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_reg       <= '0;
      cnt_reg       <= '0;
      ovf_reg       <= 1'b0;
      sum_data_reg  <= '0;
      sum_count_reg <= '0;
      sum_ovf_reg   <= 1'b0;
    end else if (prod_fire) begin
      acc_reg <= acc_plus[ACC_W-1:0];
      cnt_reg <= cnt_inc;
      ovf_reg <= ovf_reg | carry;
      if (is_final) begin
        sum_data_reg  <= acc_plus[ACC_W-1:0];
        sum_count_reg <= cnt_inc;
        sum_ovf_reg   <= ovf_reg | carry;
      end
    end else if (sum_fire) begin
      // Result taken: start the next block from zero.
      acc_reg <= '0;
      cnt_reg <= '0;
      ovf_reg <= 1'b0;
    end
  end

  assign sum_data  = sum_data_reg;
  assign sum_count = sum_count_reg;
  assign sum_ovf   = sum_ovf_reg;

endmodule

// File: tb/tb_product_accum.sv
// ---------------------------------------------------------------------------
// tb_product_accum
//   Three instances share clk and rst_n:
//     0: defaults (ACC_W=8, BLOCK_LEN=4)
//     1: ACC_W=4 (overflow cases)
//     2: BLOCK_LEN=1 (every product is its own block)
//   Inputs are driven on the falling edge, outputs sampled there as well.
// ---------------------------------------------------------------------------
module tb_product_accum;

  logic clk;
  logic rst_n;

  logic       p_valid [3];
  logic       p_last  [3];
  logic [3:0] p_data  [3];
  logic       s_ready [3];
  wire        p_ready [3];
  wire        s_valid [3];
  wire        s_ovf   [3];
  wire  [7:0] s_data  [3];
  wire  [2:0] s_count [3];

  wire  [3:0] s_data_a4;
  wire  [0:0] s_count_b1;

  int checks;
  int fails;

  product_accum dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prod_valid (p_valid[0]),
    .prod_ready (p_ready[0]),
    .prod_data  (p_data[0]),
    .prod_last  (p_last[0]),
    .sum_valid  (s_valid[0]),
    .sum_ready  (s_ready[0]),
    .sum_data   (s_data[0]),
    .sum_count  (s_count[0]),
    .sum_ovf    (s_ovf[0])
  );

  product_accum #(.ACC_W(4)) dut_a4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .prod_valid (p_valid[1]),
    .prod_ready (p_ready[1]),
    .prod_data  (p_data[1]),
    .prod_last  (p_last[1]),
    .sum_valid  (s_valid[1]),
    .sum_ready  (s_ready[1]),
    .sum_data   (s_data_a4),
    .sum_count  (s_count[1]),
    .sum_ovf    (s_ovf[1])
  );
  assign s_data[1] = {4'b0000, s_data_a4};

  product_accum #(.BLOCK_LEN(1)) dut_b1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .prod_valid (p_valid[2]),
    .prod_ready (p_ready[2]),
    .prod_data  (p_data[2]),
    .prod_last  (p_last[2]),
    .sum_valid  (s_valid[2]),
    .sum_ready  (s_ready[2]),
    .sum_data   (s_data[2]),
    .sum_count  (s_count_b1),
    .sum_ovf    (s_ovf[2])
  );
  assign s_count[2] = {2'b00, s_count_b1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer one product to instance w and return on the falling edge after it
  // has been accepted, with prod_valid dropped again.
  task automatic send(input int w, input logic [3:0] d, input logic l);
    int t;
    t = 0;
    p_valid[w] = 1'b1;
    p_data[w]  = d;
    p_last[w]  = l;
    #1;
    while (!p_ready[w] && t <= 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t > 50) begin
      checks++;
      fails++;
      $display("FAIL send_timeout dut%0d: prod_ready stuck at 0, required 1", w);
    end
    @(negedge clk);
    p_valid[w] = 1'b0;
    p_last[w]  = 1'b0;
  endtask

  // Accept the pending result of instance w with a one-cycle sum_ready pulse.
  task automatic release_result(input int w);
    s_ready[w] = 1'b1;
    @(negedge clk);
    s_ready[w] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int w = 0; w < 3; w++) p_valid[w] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      checks++;
      if (p_ready[w] !== 1'b0) begin
        fails++;
        $display("FAIL reset_prod_ready dut%0d: got %b, required 0", w, p_ready[w]);
      end
      checks++;
      if (s_valid[w] !== 1'b0 || s_data[w] !== 8'd0 || s_count[w] !== 3'd0 || s_ovf[w] !== 1'b0) begin
        fails++;
        $display("FAIL reset_outputs dut%0d: valid=%b data=%0d count=%0d ovf=%b, required all 0",
                 w, s_valid[w], s_data[w], s_count[w], s_ovf[w]);
      end
    end
    for (int w = 0; w < 3; w++) p_valid[w] = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (p_ready[0] !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: got %b, required 1", p_ready[0]);
    end
  endtask

  task automatic test_idle_ready();
    s_ready[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    s_ready[0] = 1'b0;
    checks++;
    if (s_valid[0] !== 1'b0 || p_ready[0] !== 1'b1) begin
      fails++;
      $display("FAIL idle_sum_ready: valid=%b ready=%b, required valid=0 ready=1", s_valid[0], p_ready[0]);
    end
  endtask

  task automatic test_full_block();
    send(0, 4'd9, 1'b0);
    send(0, 4'd4, 1'b0);
    send(0, 4'd1, 1'b0);
    checks++;
    if (s_valid[0] !== 1'b0) begin
      fails++;
      $display("FAIL full_block_early_valid: got %b, required 0", s_valid[0]);
    end
    send(0, 4'd6, 1'b0);
    checks++;
    if (s_valid[0] !== 1'b1 || s_data[0] !== 8'd20 || s_count[0] !== 3'd4 || s_ovf[0] !== 1'b0) begin
      fails++;
      $display("FAIL full_block_result: valid=%b data=%0d count=%0d ovf=%b, required 1/20/4/0",
               s_valid[0], s_data[0], s_count[0], s_ovf[0]);
    end
    $display("block dut0: data=%0d count=%0d ovf=%b", s_data[0], s_count[0], s_ovf[0]);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (p_ready[0] !== 1'b0 || s_valid[0] !== 1'b1) begin
        fails++;
        $display("FAIL full_block_hold: ready=%b valid=%b, required 0/1", p_ready[0], s_valid[0]);
      end
    end
    release_result(0);
    checks++;
    if (s_valid[0] !== 1'b0 || p_ready[0] !== 1'b1) begin
      fails++;
      $display("FAIL full_block_release: valid=%b ready=%b, required 0/1", s_valid[0], p_ready[0]);
    end
  endtask

  task automatic test_early_close();
    send(0, 4'd3, 1'b0);
    send(0, 4'd2, 1'b1);
    checks++;
    if (s_valid[0] !== 1'b1 || s_data[0] !== 8'd5 || s_count[0] !== 3'd2) begin
      fails++;
      $display("FAIL early_close: valid=%b data=%0d count=%0d, required 1/5/2", s_valid[0], s_data[0], s_count[0]);
    end
    $display("block dut0: data=%0d count=%0d ovf=%b", s_data[0], s_count[0], s_ovf[0]);
    release_result(0);
    for (int i = 0; i < 4; i++) send(0, 4'd1, 1'b0);
    checks++;
    if (s_valid[0] !== 1'b1 || s_data[0] !== 8'd4 || s_count[0] !== 3'd4) begin
      fails++;
      $display("FAIL early_close_next: valid=%b data=%0d count=%0d, required 1/4/4", s_valid[0], s_data[0], s_count[0]);
    end
    release_result(0);
    // prod_last on the BLOCK_LEN-th product: still one block of 4.
    send(0, 4'd1, 1'b0);
    send(0, 4'd2, 1'b0);
    send(0, 4'd3, 1'b0);
    send(0, 4'd4, 1'b1);
    checks++;
    if (s_valid[0] !== 1'b1 || s_data[0] !== 8'd10 || s_count[0] !== 3'd4) begin
      fails++;
      $display("FAIL last_on_full: valid=%b data=%0d count=%0d, required 1/10/4", s_valid[0], s_data[0], s_count[0]);
    end
    release_result(0);
    checks++;
    if (s_valid[0] !== 1'b0) begin
      fails++;
      $display("FAIL last_on_full_single_end: valid=%b, required 0", s_valid[0]);
    end
    // prod_last on the first product: block of one.
    send(0, 4'd7, 1'b1);
    checks++;
    if (s_valid[0] !== 1'b1 || s_data[0] !== 8'd7 || s_count[0] !== 3'd1) begin
      fails++;
      $display("FAIL last_on_first: valid=%b data=%0d count=%0d, required 1/7/1", s_valid[0], s_data[0], s_count[0]);
    end
    release_result(0);
  endtask

  task automatic test_backpressure();
    send(0, 4'd2, 1'b0);
    send(0, 4'd3, 1'b1);
    p_valid[0] = 1'b1;
    p_data[0]  = 4'd9;
    p_last[0]  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (p_ready[0] !== 1'b0 || s_valid[0] !== 1'b1 || s_data[0] !== 8'd5 || s_count[0] !== 3'd2 || s_ovf[0] !== 1'b0) begin
        fails++;
        $display("FAIL backpressure_hold cycle %0d: ready=%b valid=%b data=%0d count=%0d ovf=%b, required 0/1/5/2/0",
                 i, p_ready[0], s_valid[0], s_data[0], s_count[0], s_ovf[0]);
      end
    end
    release_result(0);
    checks++;
    if (p_ready[0] !== 1'b1 || s_valid[0] !== 1'b0) begin
      fails++;
      $display("FAIL backpressure_release: ready=%b valid=%b, required 1/0", p_ready[0], s_valid[0]);
    end
    @(negedge clk);  // the held 9 is taken on this edge
    p_valid[0] = 1'b0;
    send(0, 4'd1, 1'b1);
    checks++;
    if (s_valid[0] !== 1'b1 || s_data[0] !== 8'd10 || s_count[0] !== 3'd2) begin
      fails++;
      $display("FAIL backpressure_held_product: valid=%b data=%0d count=%0d, required 1/10/2",
               s_valid[0], s_data[0], s_count[0]);
    end
    release_result(0);
  endtask

  task automatic test_overflow();
    send(1, 4'd9, 1'b0);
    send(1, 4'd9, 1'b1);
    checks++;
    if (s_valid[1] !== 1'b1 || s_data[1] !== 8'd2 || s_ovf[1] !== 1'b1 || s_count[1] !== 3'd2) begin
      fails++;
      $display("FAIL overflow_wrap: valid=%b data=%0d count=%0d ovf=%b, required 1/2/2/1",
               s_valid[1], s_data[1], s_count[1], s_ovf[1]);
    end
    $display("block dut1: data=%0d count=%0d ovf=%b", s_data[1], s_count[1], s_ovf[1]);
    release_result(1);
    send(1, 4'd1, 1'b1);
    checks++;
    if (s_valid[1] !== 1'b1 || s_data[1] !== 8'd1 || s_ovf[1] !== 1'b0) begin
      fails++;
      $display("FAIL overflow_cleared: valid=%b data=%0d ovf=%b, required 1/1/0", s_valid[1], s_data[1], s_ovf[1]);
    end
    release_result(1);
  endtask

  task automatic test_reset_mid_block();
    send(0, 4'd9, 1'b0);
    send(0, 4'd9, 1'b0);
    rst_n = 1'b0;
    p_valid[0] = 1'b1;
    p_data[0]  = 4'd5;
    #1;
    checks++;
    if (p_ready[0] !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_ready: got %b, required 0", p_ready[0]);
    end
    @(negedge clk);
    p_valid[0] = 1'b0;
    rst_n = 1'b1;
    checks++;
    if (s_valid[0] !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_valid: got %b, required 0", s_valid[0]);
    end
    for (int i = 0; i < 4; i++) send(0, 4'd1, 1'b0);
    checks++;
    if (s_valid[0] !== 1'b1 || s_data[0] !== 8'd4 || s_count[0] !== 3'd4 || s_ovf[0] !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_next: valid=%b data=%0d count=%0d ovf=%b, required 1/4/4/0",
               s_valid[0], s_data[0], s_count[0], s_ovf[0]);
    end
    release_result(0);
  endtask

  task automatic test_reset_in_out();
    send(0, 4'd5, 1'b1);
    checks++;
    if (s_valid[0] !== 1'b1) begin
      fails++;
      $display("FAIL reset_out_pending: valid=%b, required 1", s_valid[0]);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (s_valid[0] !== 1'b0) begin
        fails++;
        $display("FAIL reset_out_dropped cycle %0d: valid=%b, required 0", i, s_valid[0]);
      end
      @(negedge clk);
    end
    send(0, 4'd2, 1'b1);
    checks++;
    if (s_valid[0] !== 1'b1 || s_data[0] !== 8'd2 || s_count[0] !== 3'd1) begin
      fails++;
      $display("FAIL reset_out_next: valid=%b data=%0d count=%0d, required 1/2/1", s_valid[0], s_data[0], s_count[0]);
    end
    release_result(0);
  endtask

  // Random products, closes and backpressure against a block-level model:
  // a block is the products since the last close; its result is the plain
  // integer total reduced modulo 2^ACC_W, and overflow means the total
  // reached 2^ACC_W.
  task automatic test_random(input int w, input int n_prod);
    int aw;
    int bl;
    int total;
    int cnt;
    int hold;
    logic [3:0] d;
    logic l;
    logic fin;
    aw = (w == 1) ? 4 : 8;
    bl = (w == 2) ? 1 : 4;
    total = 0;
    cnt = 0;
    for (int i = 0; i < n_prod; i++) begin
      for (int k = $urandom_range(0, 2); k > 0; k--) @(negedge clk);
      d = 4'($urandom_range(0, 15));
      l = ($urandom_range(0, 3) == 0) || (i == n_prod - 1);
      send(w, d, l);
      total += int'(d);
      cnt++;
      fin = (cnt == bl) || l;
      checks++;
      if (s_valid[w] !== fin) begin
        fails++;
        $display("FAIL random_valid dut%0d product %0d: got %b, required %b", w, i, s_valid[w], fin);
      end
      if (fin) begin
        hold = $urandom_range(0, 3);
        for (int k = 0; k < hold; k++) @(negedge clk);
        checks++;
        if (s_data[w] !== 8'(total % (1 << aw)) || s_count[w] !== 3'(cnt) ||
            s_ovf[w] !== (total >= (1 << aw))) begin
          fails++;
          $display("FAIL random_result dut%0d: data=%0d count=%0d ovf=%b, required %0d/%0d/%b",
                   w, s_data[w], s_count[w], s_ovf[w], total % (1 << aw), cnt, total >= (1 << aw));
        end else begin
          $display("block dut%0d: data=%0d count=%0d ovf=%b", w, s_data[w], s_count[w], s_ovf[w]);
        end
        release_result(w);
        total = 0;
        cnt = 0;
      end
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst_n  = 1'b0;
    for (int w = 0; w < 3; w++) begin
      p_valid[w] = 1'b0;
      p_last[w]  = 1'b0;
      p_data[w]  = 4'd0;
      s_ready[w] = 1'b0;
    end
    @(negedge clk);
    test_reset();
    test_idle_ready();
    test_full_block();
    test_early_close();
    test_backpressure();
    test_overflow();
    test_reset_mid_block();
    test_reset_in_out();
    test_random(0, 40);
    test_random(1, 40);
    test_random(2, 20);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/product_accum.md
Name: product_accum

Overview:
- Downstream consumer of the 2-bit x 2-bit multiplier's 4-bit product.
- Accepts products over a valid/ready handshake and accumulates them into a running sum. A block closes after BLOCK_LEN products, or earlier when prod_last is set.
- Presents the block sum, its product count and an overflow flag on a valid/ready output, then clears for the next block.
- Sits between the multiplier and the board-level result/LED logic.

Parameters:
- PROD_W, 4: product input width. Fixed by the multiplier; only 4 is supported.
- ACC_W, 8: accumulator and sum width. Range 4..16.
- BLOCK_LEN, 4: maximum products per block. Range 1..255.
- CNT_W (localparam), clog2(BLOCK_LEN+1): width of the count field.

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- prod_valid  in  1  upstream product valid
- prod_ready  out  1  block can accept a product
- prod_data  in  PROD_W  product value, 0..9 in practice, full 0..15 handled
- prod_last  in  1  sampled with prod_data; closes the block after this product
- sum_valid  out  1  block result available
- sum_ready  in  1  downstream accepts result
- sum_data  out  ACC_W  block sum modulo 2^ACC_W
- sum_count  out  CNT_W  number of products in block, 1..BLOCK_LEN
- sum_ovf  out  1  a carry out of ACC_W occurred during the block

Behaviour:
- Reset: synchronous. Sampled low at a rising edge, it sets:
  - state=ACC, acc=0, cnt=0, ovf=0
  - sum_valid=0, sum_data=0, sum_count=0, sum_ovf=0
  - prod_ready = (state==ACC) & rst_n, so it is 0 while rst_n is low and no handshake can complete during reset.
- Reset mid-block or while in OUT: the partial or pending result is discarded. No result is emitted for it.
- Handshakes: a transfer occurs on an edge where valid & ready. Data is ignored when valid=0.
- State ACC:
  - prod_ready=1, sum_valid=0.
  - On an accepted product: acc <= acc + zero-extended prod_data (wraps mod 2^ACC_W); cnt <= cnt+1; ovf <= ovf | carry_out.
  - The product is final if cnt+1==BLOCK_LEN or prod_last=1. On a final product, in the same edge:
    - sum_data <= acc+prod_data
    - sum_count <= cnt+1
    - sum_ovf <= ovf|carry
    - sum_valid <= 1
    - state <= OUT
- State OUT:
  - prod_ready=0, sum_valid=1.
  - sum_data, sum_count and sum_ovf are held stable until accepted.
  - On sum_ready=1 at an edge: sum_valid <= 0, acc/cnt/ovf <= 0, state <= ACC.
  - sum_data/count/ovf keep their last values after acceptance. They are don't-care while sum_valid=0.
- Latency: sum_valid rises on the edge that accepts the final product. Output is visible in the cycle after that product's handshake cycle.
- Throughput: at most one product per cycle. Each block costs at least one extra cycle in OUT, even with sum_ready held high.
- Simultaneous events:
  - prod_last=1 on the BLOCK_LEN-th product: a single block end, count=BLOCK_LEN.
  - prod_last=1 on the first product: block of 1.
  - BLOCK_LEN=1: every product is its own block.
  - prod_valid high in OUT: the product is held upstream and not accepted. It is accepted in ACC at the earliest on the cycle after the result handshake.
  - sum_ready high without sum_valid: no effect.
- Counter never exceeds BLOCK_LEN. acc wraps silently; wrap is reported only via sum_ovf.
- No combinational path from prod_valid or prod_data to any output. The only combinational paths are rst_n to prod_ready and state to prod_ready/sum_valid.

Decomposition:
- Shared package/include holds:
  - PROD_W=4 constant (common with the multiplier)
  - state encoding ACC=1'b0, OUT=1'b1
  - the clog2 helper function
- No sub-module: datapath is one adder plus a counter. The multiplier is instantiated alongside this block at the top level, not inside it.

Test Plan:
- Reset then full block: products 9,4,1,6 with prod_last=0, defaults.
  - sum_valid=1 the cycle after the 4th handshake, sum_data=20, sum_count=4, sum_ovf=0.
  - prod_ready=0 until sum_ready pulses.
- Early close: products 3,2 with prod_last=1 on the 2nd.
  - sum_data=5, sum_count=2.
  - The next block starts from 0: products 1,1,1,1 give sum_data=4.
- Backpressure: hold sum_ready=0 for 5 cycles with prod_valid=1 and data 9.
  - Outputs stable, prod_ready=0 throughout, no product lost.
  - After release, the held 9 is the first product of the next block.
- Overflow, ACC_W=4 override: products 9,9 with prod_last on the 2nd.
  - sum_data=2, sum_ovf=1.
  - The next block (product 1, last) gives sum_data=1, sum_ovf=0.
- Reset mid-block: accept 9,9, then rst_n=0 for 1 cycle.
  - prod_ready=0 during reset, sum_valid stays 0.
  - Next block 1,1,1,1 gives sum_data=4, proving acc was cleared.
- Reset while in OUT with sum_ready=0: sum_valid drops to 0 the next cycle and the result is never delivered.
